// File: rtl/msg_padder.sv
// SHA-256 message padder: takes raw big-endian host words and emits whole 512-bit blocks as 8 x 64-bit words,
// appending the 0x80 marker, zero fill and the 64-bit message bit length.
module msg_padder #(
  parameter int unsigned BCNT_W = 61
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [63:0] msg_data,
  input  logic [3:0]  msg_bytes,
  input  logic        msg_last,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [63:0] data_out,
  output logic        data_valid,
  input  logic        data_rcv,
  output logic        block_last,
  output logic [2:0]  word_idx,
  output logic        busy
);

  localparam int unsigned DW     = 64;
  localparam int unsigned NBYTES = DW / 8;
  localparam int unsigned SUM_W  = BCNT_W + 1;

  typedef enum logic [1:0] {S_DATA, S_PAD80, S_ZERO, S_LEN} state_t;

  state_t              r_state;
  logic [DW-1:0]       r_data;
  logic                r_valid;
  logic                r_block_last;
  logic [2:0]          r_idx;
  logic                r_busy;
  logic [BCNT_W-1:0]   r_bcnt;

  logic                w_xfer;
  logic                w_free;
  logic                w_accept;
  logic [2:0]          w_ld_idx;
  logic [3:0]          w_nb;
  logic [SUM_W-1:0]    w_sum;
  logic [BCNT_W-1:0]   w_bcnt_next;
  logic [DW-1:0]       w_pad_word;
  logic [DW-1:0]       w_len_word;

  assign w_xfer    = r_valid && data_rcv;
  assign w_free    = !r_valid || data_rcv;
  assign msg_ready = (r_state == S_DATA) && w_free && !rst && !clear;
  assign w_accept  = msg_valid && msg_ready;
  // Index the next loaded word will carry: a transfer this cycle advances the slot.
  assign w_ld_idx  = w_xfer ? r_idx + 3'd1 : r_idx;

  assign w_nb        = (!msg_last || msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
  assign w_sum       = {1'b0, r_bcnt} + SUM_W'(w_nb);
  assign w_bcnt_next = w_sum[BCNT_W] ? {BCNT_W{1'b1}} : w_sum[BCNT_W-1:0];
  assign w_len_word  = DW'({r_bcnt, 3'b000});

  // Keep the valid bytes, place the 0x80 marker right after them, zero the rest.
  always_comb begin
    w_pad_word = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (k < int'(w_nb))
        w_pad_word[DW-1-8*k -: 8] = msg_data[DW-1-8*k -: 8];
      else if (k == int'(w_nb))
        w_pad_word[DW-1-8*k -: 8] = 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state      <= S_DATA;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_block_last <= 1'b0;
      r_idx        <= 3'd0;
      r_busy       <= 1'b0;
      r_bcnt       <= '0;
    end else begin
      if (w_xfer) begin
        r_valid      <= 1'b0;
        r_block_last <= 1'b0;
        r_idx        <= r_idx + 3'd1;
      end
      case (r_state)
        S_DATA: begin
          if (w_accept) begin
            r_data  <= msg_last ? w_pad_word : msg_data;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_bcnt  <= w_bcnt_next;
            if (msg_last) begin
              if (w_nb == 4'd8)
                r_state <= S_PAD80;
              else
                r_state <= (w_ld_idx == 3'd6) ? S_LEN : S_ZERO;
            end
          end
        end
        S_PAD80: begin
          if (w_free) begin
            r_data  <= 64'h8000_0000_0000_0000;
            r_valid <= 1'b1;
            r_state <= (w_ld_idx == 3'd6) ? S_LEN : S_ZERO;
          end
        end
        S_ZERO: begin
          if (w_free) begin
            r_data  <= '0;
            r_valid <= 1'b1;
            if (w_ld_idx == 3'd6)
              r_state <= S_LEN;
          end
        end
        S_LEN: begin
          // Length word goes out once, then the message closes when it is taken.
          if (r_valid && r_block_last) begin
            if (data_rcv) begin
              r_state <= S_DATA;
              r_idx   <= 3'd0;
              r_busy  <= 1'b0;
              r_bcnt  <= '0;
            end
          end else if (w_free) begin
            r_data       <= w_len_word;
            r_valid      <= 1'b1;
            r_block_last <= 1'b1;
          end
        end
        default: r_state <= S_DATA;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign block_last = r_block_last;
  assign word_idx   = r_idx;
  assign busy       = r_busy;

endmodule

// File: tb/tb_msg_padder.sv
// Directed bench for msg_padder: hand-computed padded block sequences, stall, clear and reset cases.
module tb_msg_padder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [63:0] msg_data;
  logic [3:0]  msg_bytes;
  logic        msg_last;
  logic        msg_valid;
  logic        msg_ready;
  logic [63:0] data_out;
  logic        data_valid;
  logic        data_rcv;
  logic        block_last;
  logic [2:0]  word_idx;
  logic        busy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  msg_padder #(.BCNT_W(61)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .msg_data   (msg_data),
    .msg_bytes  (msg_bytes),
    .msg_last   (msg_last),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_rcv   (data_rcv),
    .block_last (block_last),
    .word_idx   (word_idx),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one host word and hold it until it is accepted.
  task automatic send(input logic [63:0] d, input logic [3:0] b, input logic l);
    int unsigned t = 0;
    msg_data  = d;
    msg_bytes = b;
    msg_last  = l;
    msg_valid = 1'b1;
    #1;
    while (!msg_ready && t < 50) begin
      step();
      t++;
    end
    chk("send_ready", 64'(msg_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  // Wait for an output word, check it, and let it transfer (data_rcv must be high).
  task automatic expect_word(input string tag, input logic [63:0] d, input logic [2:0] idx, input logic bl);
    int unsigned t = 0;
    while (!data_valid && t < 20) begin
      step();
      t++;
    end
    chk({tag, "_valid"}, 64'(data_valid), 64'(1'b1));
    chk({tag, "_data"},  data_out,        d);
    chk({tag, "_idx"},   64'(word_idx),   64'(idx));
    chk({tag, "_last"},  64'(block_last), 64'(bl));
    chk({tag, "_busy"},  64'(busy),       64'(1'b1));
    step();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_idle_valid"}, 64'(data_valid), 64'(1'b0));
    chk({tag, "_idle_busy"},  64'(busy),       64'(1'b0));
    chk({tag, "_idle_idx"},   64'(word_idx),   64'(3'd0));
  endtask

  task automatic run_abc(input string tag);
    send(64'h6162_6300_0000_0000, 4'd3, 1'b1);
    expect_word(tag, 64'h6162_6380_0000_0000, 3'd0, 1'b0);
    for (int i = 1; i < 7; i++) expect_word(tag, 64'h0, 3'(i), 1'b0);
    expect_word(tag, 64'h18, 3'd7, 1'b1);
    expect_idle(tag);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    msg_data  = '0;
    msg_bytes = '0;
    msg_last  = 1'b0;
    msg_valid = 1'b0;
    data_rcv  = 1'b1;
    step();
    chk("rst_ready", 64'(msg_ready), 64'(1'b0));
    step();
    rst = 1'b0;
    #1;
    chk("reset_data",  data_out,          64'h0);
    chk("reset_valid", 64'(data_valid),   64'(1'b0));
    chk("reset_last",  64'(block_last),   64'(1'b0));
    chk("reset_idx",   64'(word_idx),     64'(3'd0));
    chk("reset_busy",  64'(busy),         64'(1'b0));
    chk("reset_ready", 64'(msg_ready),    64'(1'b1));
    step();

    // T1 "abc"
    run_abc("t1");

    // T2 empty message
    send(64'hDEAD_BEEF_0000_0000, 4'd0, 1'b1);
    expect_word("t2", 64'h8000_0000_0000_0000, 3'd0, 1'b0);
    for (int i = 1; i < 7; i++) expect_word("t2", 64'h0, 3'(i), 1'b0);
    expect_word("t2", 64'h0, 3'd7, 1'b1);
    expect_idle("t2");

    // T3 56-byte message: marker lands at idx 7, forcing a second block
    for (int i = 0; i < 7; i++) begin
      send(64'h1111_1111_1111_1111 * 64'(i + 1), 4'd8, (i == 6));
      expect_word("t3d", 64'h1111_1111_1111_1111 * 64'(i + 1), 3'(i), 1'b0);
    end
    expect_word("t3m", 64'h8000_0000_0000_0000, 3'd7, 1'b0);
    for (int i = 0; i < 7; i++) expect_word("t3z", 64'h0, 3'(i), 1'b0);
    expect_word("t3l", 64'h1C0, 3'd7, 1'b1);
    expect_idle("t3");

    // T4 stall at idx 3
    send(64'h6162_6300_0000_0000, 4'd3, 1'b1);
    expect_word("t4", 64'h6162_6380_0000_0000, 3'd0, 1'b0);
    for (int i = 1; i < 3; i++) expect_word("t4", 64'h0, 3'(i), 1'b0);
    data_rcv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_valid", 64'(data_valid), 64'(1'b1));
      chk("t4_stall_data",  data_out,        64'h0);
      chk("t4_stall_idx",   64'(word_idx),   64'(3'd3));
      chk("t4_stall_ready", 64'(msg_ready),  64'(1'b0));
    end
    data_rcv = 1'b1;
    for (int i = 3; i < 7; i++) expect_word("t4", 64'h0, 3'(i), 1'b0);
    expect_word("t4", 64'h18, 3'd7, 1'b1);
    expect_idle("t4");

    // T5 clear at idx 4, then a clean "abc"
    send(64'h6162_6300_0000_0000, 4'd3, 1'b1);
    expect_word("t5", 64'h6162_6380_0000_0000, 3'd0, 1'b0);
    for (int i = 1; i < 4; i++) expect_word("t5", 64'h0, 3'(i), 1'b0);
    chk("t5_pre_idx", 64'(word_idx), 64'(3'd4));
    clear = 1'b1;
    #1;
    chk("t5_clear_ready", 64'(msg_ready), 64'(1'b0));
    step();
    clear = 1'b0;
    expect_idle("t5_clr");
    step();
    run_abc("t5r");

    // T6 reset mid-message, then a 9-byte message with junk past the last byte
    send(64'h0102_0304_0506_0708, 4'd8, 1'b0);
    expect_word("t6a", 64'h0102_0304_0506_0708, 3'd0, 1'b0);
    send(64'h1111_1111_1111_1111, 4'd8, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(msg_ready), 64'(1'b0));
    step();
    rst = 1'b0;
    chk("t6_rst_data", data_out,        64'h0);
    chk("t6_rst_last", 64'(block_last), 64'(1'b0));
    expect_idle("t6_rst");
    step();
    send(64'hA1A2_A3A4_A5A6_A7A8, 4'd8, 1'b0);
    expect_word("t6", 64'hA1A2_A3A4_A5A6_A7A8, 3'd0, 1'b0);
    send(64'h11AA_BBCC_DDEE_FF99, 4'd1, 1'b1);
    expect_word("t6", 64'h1180_0000_0000_0000, 3'd1, 1'b0);
    for (int i = 2; i < 7; i++) expect_word("t6", 64'h0, 3'(i), 1'b0);
    expect_word("t6", 64'h48, 3'd7, 1'b1);
    expect_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
